// File: rtl/seq_feeder.sv
// Feeds row symbols and a column stream into a systolic scoring array,
// then waits for the array's final score or a drain timeout.
module seq_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_LEN    = 4,
    parameter int COL_LEN    = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic                          ld_sel,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    input  logic                          start,
    output logic                          busy,
    output logic [DATA_WIDTH*ROW_LEN-1:0] row_data_out,
    output logic [ROW_LEN-1:0]            row_valid_out,
    output logic [DATA_WIDTH-1:0]         col_data_out,
    output logic                          col_valid_out,
    input  logic [DATA_WIDTH-1:0]         res_data,
    input  logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         score,
    output logic                          score_valid,
    output logic                          done,
    output logic                          err_ovf,
    output logic                          err_timeout
);

    localparam int RCW = $clog2(ROW_LEN + 1);
    localparam int CCW = $clog2(COL_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam int RIW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int CIW = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;

    typedef enum logic [2:0] {IDLE, ROWS, COLS, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [DATA_WIDTH-1:0] row_buf [ROW_LEN];
    logic [DATA_WIDTH-1:0] col_buf [COL_LEN];

    logic [RCW-1:0] row_cnt;
    logic [CCW-1:0] col_cnt, res_cnt, col_idx, col_idx_n;
    logic [TCW-1:0] tmo_cnt;

    logic accept, row_full, col_full, row_wr, col_wr;
    logic res_hit, drain_ok, tmo_hit;
    logic [DATA_WIDTH*ROW_LEN-1:0] row_bus;
    logic [ROW_LEN-1:0]            row_vec;

    assign accept   = ld_valid && ld_ready;
    assign row_full = (row_cnt == RCW'(ROW_LEN));
    assign col_full = (col_cnt == CCW'(COL_LEN));
    assign row_wr   = accept && !ld_sel && !row_full;
    assign col_wr   = accept && ld_sel && !col_full;
    assign res_hit  = res_valid && (state == COLS || state == DRAIN)
                      && (res_cnt < col_cnt);
    assign drain_ok = (res_cnt == col_cnt);
    assign tmo_hit  = (state == DRAIN) && !drain_ok
                      && (tmo_cnt == TCW'(TIMEOUT - 1));
    assign col_idx_n = (state == COLS) ? col_idx + 1'b1 : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start && row_cnt != '0 && col_cnt != '0) state_n = ROWS;
            ROWS:    state_n = COLS;
            COLS:    if (col_idx == col_cnt - 1'b1) state_n = DRAIN;
            DRAIN:   if (drain_ok || tmo_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Row view includes a beat written in the same cycle as start.
    always_comb begin
        row_bus = '0;
        row_vec = '0;
        for (int i = 0; i < ROW_LEN; i++) begin
            if (RCW'(i) < row_cnt) begin
                row_vec[i] = 1'b1;
                row_bus[i*DATA_WIDTH +: DATA_WIDTH] = row_buf[i];
            end else if (row_wr && RCW'(i) == row_cnt) begin
                row_vec[i] = 1'b1;
                row_bus[i*DATA_WIDTH +: DATA_WIDTH] = ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (row_wr) row_buf[row_cnt[RIW-1:0]] <= ld_data;
        if (col_wr) col_buf[col_cnt[CIW-1:0]] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt       <= '0;
            col_cnt       <= '0;
            res_cnt       <= '0;
            col_idx       <= '0;
            tmo_cnt       <= '0;
            ld_ready      <= 1'b0;
            busy          <= 1'b0;
            row_data_out  <= '0;
            row_valid_out <= '0;
            col_data_out  <= '0;
            col_valid_out <= 1'b0;
            score         <= '0;
            score_valid   <= 1'b0;
            done          <= 1'b0;
            err_ovf       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            ld_ready      <= (state_n == IDLE);
            busy          <= (state_n != IDLE);
            row_valid_out <= '0;
            col_valid_out <= 1'b0;
            score_valid   <= 1'b0;
            done          <= 1'b0;
            col_idx       <= col_idx_n;

            if (row_wr) row_cnt <= row_cnt + 1'b1;
            if (col_wr) col_cnt <= col_cnt + 1'b1;
            if (accept && (ld_sel ? col_full : row_full)) err_ovf <= 1'b1;

            if (state_n == ROWS) begin
                row_valid_out <= row_vec;
                row_data_out  <= row_bus;
                err_timeout   <= 1'b0;
            end
            if (state_n == COLS) begin
                col_valid_out <= 1'b1;
                col_data_out  <= col_buf[col_idx_n[CIW-1:0]];
            end

            if (res_hit) begin
                res_cnt <= res_cnt + 1'b1;
                if (res_cnt + 1'b1 == col_cnt) score <= res_data;
            end

            if (state != DRAIN) tmo_cnt <= '0;
            else if (tmo_cnt != TCW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) err_timeout <= 1'b1;
            if (state_n == DONE) begin
                done        <= 1'b1;
                score_valid <= !tmo_hit;
            end
            if (state == DONE) begin
                row_cnt <= '0;
                col_cnt <= '0;
                res_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_feeder.sv
// Scoreboard bench for seq_feeder: expectations are queued when a run is
// launched and retired as row, column and completion strobes appear.
module tb_seq_feeder;

    localparam int DW  = 8;
    localparam int RL  = 4;
    localparam int CL  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic          ld_sel = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic          busy;
    logic [DW*RL-1:0] row_data_out;
    logic [RL-1:0] row_valid_out;
    logic [DW-1:0] col_data_out;
    logic          col_valid_out;
    logic [DW-1:0] res_data = '0;
    logic          res_valid = 1'b0;
    logic [DW-1:0] score;
    logic          score_valid;
    logic          done;
    logic          err_ovf;
    logic          err_timeout;

    seq_feeder #(
        .DATA_WIDTH(DW), .ROW_LEN(RL), .COL_LEN(CL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_data(ld_data),
        .start(start), .busy(busy),
        .row_data_out(row_data_out), .row_valid_out(row_valid_out),
        .col_data_out(col_data_out), .col_valid_out(col_valid_out),
        .res_data(res_data), .res_valid(res_valid),
        .score(score), .score_valid(score_valid), .done(done),
        .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_row  [$];
    logic [63:0] exp_col  [$];
    logic [63:0] exp_done [$];

    logic [DW-1:0] mrow [RL];
    logic [DW-1:0] mcol [CL];
    logic [DW-1:0] res_vals [CL];
    int            mr, mc;
    logic [DW-1:0] mscore;
    logic          movf;
    int            lat;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst) begin
        if (row_valid_out != '0) begin
            if (exp_row.size() == 0) chk("row_unexp", 1, 0);
            else chk("row", {row_valid_out, row_data_out}, exp_row.pop_front());
        end
        if (col_valid_out) begin
            if (exp_col.size() == 0) chk("col_unexp", 1, 0);
            else chk("col", col_data_out, exp_col.pop_front());
        end
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexp", 1, 0);
            else chk("done", {err_timeout, score_valid, score},
                     exp_done.pop_front());
        end
        if (score_valid && !done) chk("sv_nodone", 1, 0);
    end

    task automatic model_clear();
        mr = 0; mc = 0; mscore = '0; movf = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [DW-1:0] d);
        int n = 0;
        while (!ld_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!ld_ready) chk("ld_wait", 0, 1);
        ld_valid = 1'b1; ld_sel = sel; ld_data = d;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        if (sel) begin
            if (mc < CL) begin mcol[mc] = d; mc++; end
            else movf = 1'b1;
        end else begin
            if (mr < RL) begin mrow[mr] = d; mr++; end
            else movf = 1'b1;
        end
    endtask

    task automatic push_exp(input int np);
        logic [RL-1:0]    v = '0;
        logic [DW*RL-1:0] b = '0;
        logic             to;
        for (int i = 0; i < mr; i++) begin
            v[i] = 1'b1;
            b[i*DW +: DW] = mrow[i];
        end
        exp_row.push_back({28'd0, v, b});
        for (int k = 0; k < mc; k++) exp_col.push_back({56'd0, mcol[k]});
        to = (np < mc);
        if (!to) mscore = res_vals[mc-1];
        exp_done.push_back({54'd0, to, !to, mscore});
    endtask

    task automatic run(input int np, output int latency);
        int n = 0;
        int s;
        push_exp(np);
        s = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1 + mc) begin @(posedge clk); #1; end
        for (int k = 0; k < np; k++) begin
            res_valid = 1'b1; res_data = res_vals[k];
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        while (!done && n < TMO + 40) begin @(posedge clk); #1; n++; end
        if (!done) chk("done_wait", 0, 1);
        latency = cyc - s;
        @(posedge clk); #1;
        mr = 0; mc = 0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", ld_ready, 1);
        chk("post_rst_busy", busy, 0);

        // nominal run
        load(0, 8'h41); load(0, 8'h43); load(0, 8'h47); load(0, 8'h54);
        load(1, 8'h41); load(1, 8'h47); load(1, 8'h43); load(1, 8'h54);
        res_vals[0] = 8'd1; res_vals[1] = 8'd2;
        res_vals[2] = 8'd3; res_vals[3] = 8'd5;
        run(4, lat);
        chk("nom_score", score, 8'd5);
        chk("nom_ovf", err_ovf, movf);
        chk("nom_tmo", err_timeout, 0);

        // column overflow
        load(0, 8'h11);
        for (int k = 0; k < 9; k++) load(1, 8'(k));
        chk("ovf_flag", err_ovf, movf);
        chk("ovf_mc", mc, CL);
        for (int k = 0; k < CL; k++) res_vals[k] = 8'(8'h10 + k);
        run(8, lat);
        chk("ovf_sticky", err_ovf, 1);

        // partial rows
        load(0, 8'h0A); load(0, 8'h0B); load(1, 8'h33);
        res_vals[0] = 8'h77;
        run(1, lat);
        chk("part_score", score, 8'h77);

        // empty column guard
        load(0, 8'h21);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("guard_busy", busy, 0);
            @(posedge clk); #1;
        end

        // drain timeout then a clean run
        load(0, 8'h22);
        for (int k = 0; k < 4; k++) load(1, 8'(8'hC0 + k));
        res_vals[0] = 8'h90; res_vals[1] = 8'h91;
        run(2, lat);
        chk("tmo_latency", lat, 2 + 4 + TMO);
        chk("tmo_flag", err_timeout, 1);
        chk("tmo_score_hold", score, 8'h77);
        load(0, 8'h31); load(1, 8'h32);
        res_vals[0] = 8'h44;
        run(1, lat);
        chk("tmo_cleared", err_timeout, 0);
        chk("clean_score", score, 8'h44);

        // reset in the middle of the column stream
        for (int k = 0; k < 4; k++) load(0, 8'(8'h51 + k));
        for (int k = 0; k < 4; k++) load(1, 8'(8'h61 + k));
        push_exp(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_col_valid", col_valid_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err_ovf", err_ovf, 0);
        chk("mid_colq", exp_col.size(), 2);
        exp_row.delete(); exp_col.delete(); exp_done.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_ready", ld_ready, 1);
        chk("mid_busy2", busy, 0);
        load(0, 8'h01); load(0, 8'h02); load(0, 8'h03);
        load(1, 8'h09); load(1, 8'h08); load(1, 8'h07);
        res_vals[0] = 8'h0C; res_vals[1] = 8'h0D; res_vals[2] = 8'h0E;
        run(3, lat);
        chk("reload_score", score, 8'h0E);

        repeat (3) @(posedge clk);
        #1;
        chk("rowq_left", exp_row.size(), 0);
        chk("colq_left", exp_col.size(), 0);
        chk("doneq_left", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_feeder.md
SEQ_FEEDER -- requirements
Module: seq_feeder

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 8, symbol/score width; ROW_LEN, default 4, array rows / row-buffer depth; COL_LEN, default 8, column-buffer depth; TIMEOUT, default 64, drain-wait limit in cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready
- ld_sel  in  1  0 = row buffer, 1 = column buffer
- ld_data  in  DATA_WIDTH  symbol
- start  in  1  launch request
- busy  out  1  high in every state except IDLE
- row_data_out  out  DATA_WIDTH*ROW_LEN  per-row symbol, row i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- row_valid_out  out  ROW_LEN  per-row load strobe
- col_data_out  out  DATA_WIDTH  column symbol stream into the array
- col_valid_out  out  1  column stream valid
- res_data  in  DATA_WIDTH  score from the array's final PE
- res_valid  in  1  score valid
- score  out  DATA_WIDTH  captured final score
- score_valid  out  1  one-cycle final-score strobe
- done  out  1  one-cycle completion strobe
- err_ovf  out  1  sticky load-overflow flag
- err_timeout  out  1  timeout flag for the last run

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have states IDLE, ROWS, COLS, DRAIN, DONE.
REQ-005 ld_ready SHALL be 1 only in IDLE.
- Accepted beat with ld_sel=0 writes row_buf[row_cnt] and increments row_cnt.
- Accepted beat with ld_sel=1 writes col_buf[col_cnt] and increments col_cnt.
REQ-006 A beat accepted when its target count already equals its depth SHALL be discarded, leave the count unchanged, and set err_ovf; err_ovf clears only on reset.
REQ-007 start in IDLE SHALL move the FSM to ROWS only when row_cnt>0 and col_cnt>0.
- Otherwise start is ignored.
- start outside IDLE is ignored.
- A simultaneous accepted load beat is still written.
REQ-008 ROWS SHALL last exactly 1 cycle.
- row_valid_out[i]=1 and row slice i = row_buf[i] for i<row_cnt; other bits 0.
- Next state is COLS.
REQ-009 COLS SHALL last exactly col_cnt cycles.
- col_valid_out=1; col_data_out = col_buf[k] for k = 0..col_cnt-1 in order.
- Next state is DRAIN.
REQ-010 Outside ROWS/COLS, row_valid_out and col_valid_out SHALL be 0 and the data outputs SHALL hold their last value.
REQ-011 res_valid pulses SHALL be counted in COLS and DRAIN and ignored in IDLE and DONE.
- res_data SHALL be captured into score on the pulse that brings the count to col_cnt.
- Later pulses are ignored.
REQ-012 DRAIN SHALL exit to DONE when the count reaches col_cnt, including on the entry cycle if it is already complete.
REQ-013 If the count has not reached col_cnt after TIMEOUT cycles in DRAIN, the FSM SHALL go to DONE with err_timeout=1.
REQ-014 DONE SHALL last 1 cycle.
- done=1.
- score_valid=1 only if no timeout.
- row_cnt, col_cnt and the result count clear to 0.
- Next state is IDLE.
REQ-015 err_timeout SHALL be cleared when the next run enters ROWS.
REQ-016 Counter widths SHALL be clog2(depth+1); the timeout counter SHALL saturate and not wrap.

Reset
REQ-017 rst low SHALL immediately, asynchronously:
- force the FSM to IDLE;
- clear all counts;
- set every output to 0, including err_ovf and err_timeout.
Buffer contents need not be cleared.
REQ-018 A reset asserted mid-run SHALL abort the run with no done or score_valid pulse.
- The first post-reset cycle has ld_ready=1 and busy=0.

Verification
REQ-019 Nominal run: rows 41,43,47,54 and cols 41,47,43,54 (hex), then start.
- Next cycle: row_valid_out=4'b1111 with those slices.
- Then 4 cycles of col stream 41,47,43,54.
- Then res pulses 1,2,3,5 give score=5 and one cycle of score_valid=1 and done=1.
REQ-020 Overflow: 9 column beats 00..08.
- col_cnt=8; err_ovf=1.
- The stream after start is 00..07 only.
REQ-021 Partial rows: 2 row beats 0A,0B and 1 column beat.
- row_valid_out=4'b0011 with slices 0A,0B.
- 1 column cycle.
REQ-022 Empty guard: start with col_cnt=0.
- busy stays 0; no strobes.
REQ-023 Timeout: 4 columns, only 2 res pulses.
- 64 cycles after DRAIN entry, done=1, err_timeout=1, score_valid=0.
- A following valid run clears err_timeout.
REQ-024 Reset mid-COLS (after 2 of 4 symbols):
- col_valid_out=0 and busy=0 without waiting for a clock edge.
- No done pulse.
- The reloaded sequences run correctly.
